// File: rtl/sync_fifo_reader.sv
// Read-side controller for a single-clock FIFO. It hides the FIFO's one-cycle read latency
// behind a 2-entry lookahead buffer and presents a valid/ready stream with a delivered-word count.
module sync_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  pop;
  logic [1:0]            claimed;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign pop       = out_valid && out_ready;
  assign out_data  = entry0_q;
  assign rd_count  = count_q;
  assign busy      = out_valid || inflight_q;

  // Slots already spoken for after this edge: buffered words plus the word in flight,
  // minus the one leaving now. A new read is only issued if a slot will remain free.
  assign claimed = occ_q + {1'b0, inflight_q} - {1'b0, pop};

  assign fifo_read_en = reset && enable && !fifo_empty && (claimed < 2'd2);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    occ_d    = occ_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;

    if (pop) begin
      count_d = count_q + CNT_WIDTH'(1);
    end

    case ({inflight_q, pop})
      2'b11: begin
        // Capture and pop together: occupancy unchanged, order preserved.
        if (occ_q == OCC_TWO) begin
          entry0_d = entry1_q;
          entry1_d = fifo_data;
        end else begin
          entry0_d = fifo_data;
        end
      end
      2'b10: begin
        case (occ_q)
          OCC_EMPTY: begin
            entry0_d = fifo_data;
            occ_d    = OCC_ONE;
          end
          OCC_ONE: begin
            entry1_d = fifo_data;
            occ_d    = OCC_TWO;
          end
          default: begin
            occ_d = occ_q;
          end
        endcase
      end
      2'b01: begin
        if (occ_q == OCC_TWO) begin
          entry0_d = entry1_q;
          occ_d    = OCC_ONE;
        end else begin
          occ_d = OCC_EMPTY;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the two data entries are plain registers, not a memory array, so they are
      // reset along with the control state and out_data reads 0 after reset.
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      entry0_q   <= '0;
      entry1_q   <= '0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      occ_q      <= occ_d;
      inflight_q <= fifo_read_en;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Self-checking bench for sync_fifo_reader: a queue-based FIFO and output-buffer model,
// a table-driven streaming vector set, hand-written corner sequences and random traffic.
module tb_sync_fifo_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_read_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] rd_count;
  logic          busy;

  sync_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rd_count     (rd_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Environment FIFO contents and the order words must come out in.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];

  // Reference model: words sitting in the output buffer, and the word in flight.
  logic [DW-1:0] m_buf[$];
  logic          m_flight;
  logic [DW-1:0] m_flight_word;
  int            m_count;

  typedef struct packed {
    logic          en;
    logic          rdy;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_cnt;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_buf.delete();
    m_flight      = 1'b0;
    m_flight_word = '0;
    m_count       = 0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: FIFO pops on a sampled read, model and scoreboard advance.
  task automatic tick();
    logic rd;
    logic m_pop;
    logic dut_pop;
    rd      = fifo_read_en;
    m_pop   = (m_buf.size() > 0) && out_ready;
    dut_pop = out_valid && out_ready;
    if (dut_pop) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL order: word %0h delivered with nothing outstanding", out_data);
      end else begin
        check("order", out_data, sb_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (!reset) begin
      model_clear();
    end else begin
      if (m_pop) begin
        void'(m_buf.pop_front());
        m_count++;
      end
      if (m_flight) m_buf.push_back(m_flight_word);
      m_flight      = rd;
      m_flight_word = fifo_data;
    end
  endtask

  task automatic check_model();
    int claimed;
    logic exp_rd;
    claimed = m_buf.size() + int'(m_flight) - int'((m_buf.size() > 0) && out_ready);
    exp_rd  = reset && enable && !fifo_empty && (claimed < 2);
    check("read_en", fifo_read_en, exp_rd);
    check("out_valid", out_valid, m_buf.size() > 0);
    if (m_buf.size() > 0) check("out_data", out_data, m_buf[0]);
    check("rd_count", rd_count, m_count % (1 << CW));
    check("busy", busy, (m_buf.size() > 0) || m_flight);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_q.delete();
    sb_q.delete();
    fifo_empty = 1'b1;
    model_clear();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    int seen;
    int popped;
    logic [DW-1:0] got[$];

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 4'd0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hB2, 4'd1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 4'd2, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd3, 1'b0};

    reset      = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    model_clear();

    // Reset held low with a non-empty FIFO and enable high.
    load(8'h01);
    load(8'h02);
    repeat (2) tick();
    #1;
    check("rst_read_en", fifo_read_en, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", rd_count, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data, 0);

    // Streaming table: A1,B2,C3 with downstream always ready.
    do_reset();
    load(8'hA1);
    load(8'hB2);
    load(8'hC3);
    for (int i = 0; i < 6; i++) begin
      enable    = vecs[i].en;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_rd", i), fifo_read_en, vecs[i].exp_rd);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_cnt", i), rd_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      tick();
    end

    // Backpressure: only two reads may issue, head holds the first word.
    do_reset();
    load(8'h11);
    load(8'h22);
    load(8'h33);
    load(8'h44);
    enable    = 1'b1;
    out_ready = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_model();
      if (fifo_read_en) pulses++;
      tick();
    end
    check("bp_pulses", pulses, 2);
    check("bp_valid", out_valid, 1'b1);
    check("bp_head", out_data, 8'h11);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      #1;
      check_model();
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    check("bp_words", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check($sformatf("bp_word%0d", i), got[i], 8'h11 * (i + 1));
    check("bp_count", rd_count, 4);

    // Single word followed by an empty FIFO.
    do_reset();
    load(8'h5A);
    enable    = 1'b1;
    out_ready = 1'b1;
    pulses    = 0;
    seen      = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_model();
      if (fifo_read_en) pulses++;
      if (out_valid && out_ready) begin
        seen++;
        check("empty_word", out_data, 8'h5A);
      end
      tick();
    end
    check("empty_pulses", pulses, 1);
    check("empty_seen", seen, 1);
    check("empty_valid", out_valid, 1'b0);
    check("empty_read_en", fifo_read_en, 1'b0);
    check("empty_count", rd_count, 1);

    // Enable drops right after a read issues; the in-flight word still arrives.
    do_reset();
    load(8'h71);
    load(8'h72);
    load(8'h73);
    enable    = 1'b1;
    out_ready = 1'b1;
    #1;
    check("en_issue", fifo_read_en, 1'b1);
    tick();
    enable = 1'b0;
    #1;
    check("en_drop", fifo_read_en, 1'b0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      check_model();
      if (out_valid && out_ready) begin
        seen++;
        check("en_word", out_data, 8'h71);
      end
      tick();
      #1;
    end
    check("en_seen", seen, 1);
    check("en_count", rd_count, 1);
    check("en_busy", busy, 1'b0);

    // Asynchronous reset with the buffer full and words already delivered.
    do_reset();
    for (int i = 0; i < 6; i++) load(8'h61 + 8'(i));
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_model();
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_model();
      tick();
    end
    #1;
    check_model();
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_cnt_nz", rd_count != 0, 1'b1);
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", rd_count, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_read_en", fifo_read_en, 1'b0);
    model_clear();

    // Counter wrap: sixteen pops return a 4-bit count to zero.
    do_reset();
    for (int i = 0; i < 16; i++) load(8'(i * 3));
    enable    = 1'b1;
    out_ready = 1'b1;
    popped    = 0;
    for (int i = 0; i < 40 && popped < 16; i++) begin
      #1;
      check_model();
      if (out_valid && out_ready) popped++;
      tick();
    end
    #1;
    check("wrap_pops", popped, 16);
    check("wrap_count", rd_count, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(2) == 0 && fifo_q.size() < 6) load(8'($urandom));
      enable    = ($urandom_range(4) != 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      check_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
